// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 scan-code receiver and its consumers.
//   - ps2_state_t and ST_* : receiver FSM state encoding
//   - KEY_0..KEY_9, ENTER, BACKSPACE, RELEASE : set-2 scan codes used by the
//     keypad/BPM input controllers
package ps2_pkg;

    typedef logic [1:0] ps2_state_t;

    localparam ps2_state_t ST_IDLE   = 2'd0;
    localparam ps2_state_t ST_DATA   = 2'd1;
    localparam ps2_state_t ST_PARITY = 2'd2;
    localparam ps2_state_t ST_STOP   = 2'd3;

    localparam logic [7:0] KEY_0     = 8'h45;
    localparam logic [7:0] KEY_1     = 8'h16;
    localparam logic [7:0] KEY_2     = 8'h1E;
    localparam logic [7:0] KEY_3     = 8'h26;
    localparam logic [7:0] KEY_4     = 8'h25;
    localparam logic [7:0] KEY_5     = 8'h2E;
    localparam logic [7:0] KEY_6     = 8'h36;
    localparam logic [7:0] KEY_7     = 8'h3D;
    localparam logic [7:0] KEY_8     = 8'h3E;
    localparam logic [7:0] KEY_9     = 8'h46;
    localparam logic [7:0] ENTER     = 8'h5A;
    localparam logic [7:0] BACKSPACE = 8'h66;
    localparam logic [7:0] RELEASE   = 8'hF0;

endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: PS/2 line front end.
// Synchronizes PS2_CLK and PS2_DAT, debounces the clock and emits a one-cycle
// pulse when the filtered clock falls.
// Ports:
//   Clock, nReset  : system clock, asynchronous active-low reset
//   PS2_CLK        : raw keyboard clock (asynchronous)
//   PS2_DAT        : raw keyboard data (asynchronous)
//   fall           : one-cycle pulse on a filtered 1->0 clock transition
//   dat_sync       : synchronized keyboard data
module ps2_clk_filter
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 8
) (
    input  logic Clock,
    input  logic nReset,
    input  logic PS2_CLK,
    input  logic PS2_DAT,
    output logic fall,
    output logic dat_sync
);

    localparam int unsigned CntW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   filt_q, filt_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   fall_q, fall_d;
    logic                   clk_s;

    assign clk_s = clk_sync_q[SYNC_STAGES-1];

    // cnt counts consecutive synced samples that disagree with the filtered
    // level; any agreeing sample restarts the count, so short glitches vanish.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        fall_d = 1'b0;
        if (clk_s != filt_q) begin
            if (cnt_q == CntW'(FILTER_LEN - 1)) begin
                filt_d = clk_s;
                fall_d = filt_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // Idle-high reset values keep the line from looking like a falling edge.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            filt_q     <= 1'b1;
            cnt_q      <= '0;
            fall_q     <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], PS2_CLK};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], PS2_DAT};
            filt_q     <= filt_d;
            cnt_q      <= cnt_d;
            fall_q     <= fall_d;
        end
    end

    assign fall     = fall_q;
    assign dat_sync = dat_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 keyboard receiver producing validated scan-code bytes.
// Frame: start(0), D0..D7 LSB first, odd parity, stop(1). No make/break decoding.
// Ports:
//   Clock, nReset  : system clock (50 MHz nominal), asynchronous active-low reset
//   PS2_CLK        : raw keyboard clock, idle high
//   PS2_DAT        : raw keyboard data, idle high
//   data           : last valid scan-code byte, held until the next one
//   data_en        : one-cycle strobe, data valid in the same cycle
//   frame_err      : one-cycle strobe on a rejected (or timed-out) frame
// Build option: define PS2_RX_TIMEOUT_EN to abort partial frames after
// TIMEOUT_CYCLES clocks without a PS/2 falling edge.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] data,
    output logic       data_en,
    output logic       frame_err
);

    logic       fall;
    logic       dat_sync;
    logic       timeout;

    ps2_state_t state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       parity_q, parity_d;
    logic [7:0] data_q, data_d;
    logic       data_en_q, data_en_d;
    logic       frame_err_q, frame_err_d;
    logic       frame_ok;

    ps2_clk_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_clk_filter (
        .Clock    (Clock),
        .nReset   (nReset),
        .PS2_CLK  (PS2_CLK),
        .PS2_DAT  (PS2_DAT),
        .fall     (fall),
        .dat_sync (dat_sync)
    );

`ifdef PS2_RX_TIMEOUT_EN
    localparam int unsigned WdogW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WdogW-1:0] wdog_q, wdog_d;

    // wdog_q holds the number of fall-free cycles already elapsed; the cycle
    // that would complete TIMEOUT_CYCLES of them fires the abort.
    always_comb begin
        wdog_d  = wdog_q;
        timeout = 1'b0;
        if (state_q == ST_IDLE || fall) begin
            wdog_d = '0;
        end else if (wdog_q == WdogW'(TIMEOUT_CYCLES - 1)) begin
            wdog_d  = '0;
            timeout = 1'b1;
        end else begin
            wdog_d = wdog_q + WdogW'(1);
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    assign frame_ok = (^{shift_q, parity_q}) & dat_sync;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        data_d      = data_q;
        data_en_d   = 1'b0;
        frame_err_d = 1'b0;
        // timeout only fires in a cycle without fall, so it never collides
        // with the stop-bit verdict.
        if (timeout) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = 3'd0;
            frame_err_d = 1'b1;
        end else if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!dat_sync) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_d = {dat_sync, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                ST_PARITY: begin
                    parity_d = dat_sync;
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    if (frame_ok) begin
                        data_d    = shift_q;
                        data_en_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d   = ST_IDLE;
                    bit_cnt_d = 3'd0;
                end
                default: begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            parity_q    <= 1'b0;
            data_q      <= 8'h00;
            data_en_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            data_q      <= data_d;
            data_en_q   <= data_en_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data      = data_q;
    assign data_en   = data_en_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx: directed self-checking bench for ps2_scancode_rx.
// The PS/2 clock is run much faster than a real keyboard (HALF system cycles per
// half-period) to keep the run short; it stays well above FILTER_LEN.
module tb_ps2_scancode_rx;
    import ps2_pkg::*;

    localparam int unsigned HALF = 50;
    localparam int unsigned TO   = 400;

    logic       Clock   = 1'b0;
    logic       nReset  = 1'b0;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DAT = 1'b1;
    logic [7:0] data;
    logic       data_en;
    logic       frame_err;

    int checks = 0;
    int passed = 0;

    always #5 Clock = ~Clock;

    ps2_scancode_rx #(
        .SYNC_STAGES    (2),
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .Clock     (Clock),
        .nReset    (nReset),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .data      (data),
        .data_en   (data_en),
        .frame_err (frame_err)
    );

    // Event monitor: strobe counts, captured bytes, and timing stamps.
    int         cyc = 0;
    int         en_cnt = 0;
    int         err_cnt = 0;
    int         fall_cnt = 0;
    int         both_cnt = 0;
    int         last_fall_cyc = 0;
    int         last_err_cyc = 0;
    logic [7:0] en_log[$];

    always @(negedge Clock) begin
        cyc = cyc + 1;
        if (data_en) begin
            en_cnt = en_cnt + 1;
            en_log.push_back(data);
        end
        if (frame_err) begin
            err_cnt = err_cnt + 1;
            last_err_cyc = cyc;
        end
        if (data_en && frame_err) both_cnt = both_cnt + 1;
        if (dut.u_clk_filter.fall) begin
            fall_cnt = fall_cnt + 1;
            last_fall_cyc = cyc;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic send_bit(input logic b);
        PS2_DAT = b;
        wait_cycles(HALF);
        PS2_CLK = 1'b0;
        wait_cycles(HALF);
        PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
        PS2_DAT = 1'b1;
        wait_cycles(20);
    endtask

    task automatic test_reset;
        wait_cycles(5);
        checks++;
        if (data !== 8'h00) $display("FAIL reset_data: got %h expected 00", data);
        else passed++;
        checks++;
        if (data_en !== 1'b0) $display("FAIL reset_data_en: got %b expected 0", data_en);
        else passed++;
        checks++;
        if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b expected 0", frame_err);
        else passed++;
        checks++;
        if (dut.state_q !== ST_IDLE)
            $display("FAIL reset_state: got %0d expected %0d", dut.state_q, ST_IDLE);
        else passed++;
        nReset = 1'b1;
        wait_cycles(20);
    endtask

    task automatic test_single_frame;
        int e0, r0;
        e0 = en_cnt;
        r0 = err_cnt;
        send_frame(KEY_1, 1'b0, 1'b1);
        checks++;
        if (en_cnt - e0 != 1) $display("FAIL single_en_count: got %0d expected 1", en_cnt - e0);
        else passed++;
        checks++;
        if (err_cnt - r0 != 0) $display("FAIL single_err_count: got %0d expected 0", err_cnt - r0);
        else passed++;
        checks++;
        if (data !== 8'h16) $display("FAIL single_data: got %h expected 16", data);
        else passed++;
    endtask

    task automatic test_back_to_back;
        int e0, r0;
        e0 = en_cnt;
        r0 = err_cnt;
        en_log.delete();
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(RELEASE[i]);
        send_bit(1'b1);
        send_bit(1'b1);
        send_frame(8'h16, 1'b0, 1'b1);
        checks++;
        if (en_cnt - e0 != 2) $display("FAIL b2b_en_count: got %0d expected 2", en_cnt - e0);
        else passed++;
        checks++;
        if (en_log[0] !== 8'hF0) $display("FAIL b2b_first: got %h expected f0", en_log[0]);
        else passed++;
        checks++;
        if (en_log[1] !== 8'h16) $display("FAIL b2b_second: got %h expected 16", en_log[1]);
        else passed++;
        checks++;
        if (err_cnt - r0 != 0) $display("FAIL b2b_err_count: got %0d expected 0", err_cnt - r0);
        else passed++;
    endtask

    task automatic test_parity_error;
        int e0, r0;
        e0 = en_cnt;
        r0 = err_cnt;
        send_frame(8'h5A, 1'b0, 1'b1);
        checks++;
        if (err_cnt - r0 != 1) $display("FAIL parity_err_count: got %0d expected 1", err_cnt - r0);
        else passed++;
        checks++;
        if (en_cnt - e0 != 0) $display("FAIL parity_en_count: got %0d expected 0", en_cnt - e0);
        else passed++;
        checks++;
        if (data !== 8'h16) $display("FAIL parity_data_held: got %h expected 16", data);
        else passed++;
        e0 = en_cnt;
        send_frame(8'h45, 1'b0, 1'b1);
        checks++;
        if (en_cnt - e0 != 1) $display("FAIL after_parity_en: got %0d expected 1", en_cnt - e0);
        else passed++;
        checks++;
        if (data !== 8'h45) $display("FAIL after_parity_data: got %h expected 45", data);
        else passed++;
    endtask

    task automatic test_stop_error;
        int e0, r0;
        e0 = en_cnt;
        r0 = err_cnt;
        // 0x3D has five ones, so parity 0 is correct; only the stop bit is bad.
        send_frame(8'h3D, 1'b0, 1'b0);
        checks++;
        if (err_cnt - r0 != 1) $display("FAIL stop_err_count: got %0d expected 1", err_cnt - r0);
        else passed++;
        checks++;
        if (en_cnt - e0 != 0) $display("FAIL stop_en_count: got %0d expected 0", en_cnt - e0);
        else passed++;
        checks++;
        if (data !== 8'h45) $display("FAIL stop_data_held: got %h expected 45", data);
        else passed++;
    endtask

    task automatic test_glitch;
        int e0, r0, f0;
        e0 = en_cnt;
        r0 = err_cnt;
        f0 = fall_cnt;
        for (int i = 0; i < 4; i++) begin
            PS2_CLK = 1'b0;
            wait_cycles(3);
            PS2_CLK = 1'b1;
            wait_cycles(20);
        end
        checks++;
        if (fall_cnt - f0 != 0) $display("FAIL glitch_falls: got %0d expected 0", fall_cnt - f0);
        else passed++;
        checks++;
        if (dut.state_q !== ST_IDLE)
            $display("FAIL glitch_state: got %0d expected %0d", dut.state_q, ST_IDLE);
        else passed++;
        checks++;
        if ((en_cnt - e0) + (err_cnt - r0) != 0)
            $display("FAIL glitch_strobes: got %0d expected 0", (en_cnt - e0) + (err_cnt - r0));
        else passed++;
    endtask

`ifdef PS2_RX_TIMEOUT_EN
    task automatic test_timeout;
        int e0, r0;
        logic [7:0] partial;
        partial = 8'hA5;
        e0 = en_cnt;
        r0 = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(partial[i]);
        wait_cycles(TO + 100);
        checks++;
        if (err_cnt - r0 != 1) $display("FAIL timeout_err_count: got %0d expected 1", err_cnt - r0);
        else passed++;
        // TO fall-free cycles elapse, then the registered strobe appears.
        checks++;
        if (last_err_cyc - last_fall_cyc != TO + 1)
            $display("FAIL timeout_latency: got %0d expected %0d",
                     last_err_cyc - last_fall_cyc, TO + 1);
        else passed++;
        checks++;
        if (en_cnt - e0 != 0) $display("FAIL timeout_en_count: got %0d expected 0", en_cnt - e0);
        else passed++;
        send_frame(ENTER, 1'b1, 1'b1);
        checks++;
        if (data !== 8'h5A) $display("FAIL after_timeout_data: got %h expected 5a", data);
        else passed++;
    endtask
`endif

    task automatic test_reset_mid_frame;
        int e0, r0;
        logic [7:0] d;
        d = KEY_2;
        e0 = en_cnt;
        r0 = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(d[i]);
        wait_cycles(10);
        nReset = 1'b0;
        wait_cycles(3);
        checks++;
        if (data !== 8'h00) $display("FAIL midreset_data: got %h expected 00", data);
        else passed++;
        checks++;
        if (data_en !== 1'b0 || frame_err !== 1'b0)
            $display("FAIL midreset_strobes: got %b%b expected 00", data_en, frame_err);
        else passed++;
        wait_cycles(10);
        nReset = 1'b1;
        wait_cycles(20);
        checks++;
        if ((en_cnt - e0) + (err_cnt - r0) != 0)
            $display("FAIL midreset_no_strobe: got %0d expected 0", (en_cnt - e0) + (err_cnt - r0));
        else passed++;
        send_frame(8'h1E, 1'b1, 1'b1);
        checks++;
        if (en_cnt - e0 != 1) $display("FAIL after_reset_en: got %0d expected 1", en_cnt - e0);
        else passed++;
        checks++;
        if (data !== 8'h1E) $display("FAIL after_reset_data: got %h expected 1e", data);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_parity_error();
        test_stop_error();
        test_glitch();
`ifdef PS2_RX_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_frame();
        checks++;
        if (both_cnt != 0) $display("FAIL strobe_exclusive: got %0d expected 0", both_cnt);
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
